// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART 8N1 transmit serialiser fed by a small byte FIFO
//
// Purpose:
//   Accepts bytes from the execute stage and queues them in a FIFO_DEPTH-entry FIFO.
//   Each byte is sent on uart_tx as one start bit, eight data bits (LSB first) and one
//   stop bit. Every bit lasts CLKS_PER_BIT clocks. Back-to-back frames have no idle gap.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset (release synchronised externally)
//   tx_req   in   1  enqueue tx_data this cycle (dropped when FIFO full)
//   tx_data  in   8  byte to enqueue
//   tx_busy  out  1  FIFO full
//   tx_idle  out  1  FIFO empty and serialiser idle
//   uart_tx  out  1  registered serial line, idle high

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic       uart_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [BW-1:0]   baud_cnt, baud_cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push, pop, bit_end, line_next;

  assign bit_end = (baud_cnt == BAUD_LAST);
  // Occupancy before the edge decides acceptance, so a same-edge pop cannot rescue a
  // request made while full.
  assign push    = tx_req && (count != CNT_FULL);
  assign tx_busy = (count == CNT_FULL);
  assign tx_idle = (state == IDLE) && (count == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and serialiser datapath decode
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          bit_idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          baud_cnt_next = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          // Chain directly into the next start bit when more data is waiting.
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: the line value for the state being entered, so the registered
  // uart_tx changes on the same edge as the state.
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[0];
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      uart_tx   <= line_next;
    end
  end

  // FIFO pointers and occupancy; reset flushes by clearing these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_idle, uart_tx;

  int checks = 0;
  int errors = 0;

  logic       sc_req [0:1023];
  logic [7:0] sc_dat [0:1023];

  uart_tx_fifo #(
    .CLK_FREQ  (16),
    .BAUD      (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_idle (tx_idle),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_sc();
    for (int i = 0; i < 1024; i++) begin
      sc_req[i] = 1'b0;
      sc_dat[i] = 8'h00;
    end
  endtask

  // Line level at offset o (0..39) into a frame carrying byte b, 4 clocks per bit.
  function automatic logic frame_bit(input logic [7:0] b, input int o);
    if (o < 4)  return 1'b0;
    if (o < 36) return b[(o - 4) / 4];
    return 1'b1;
  endfunction

  // Drives sc_req/sc_dat on edges 0..ncyc-1 and compares the outputs after every edge
  // with a transaction-level model: a byte queue, and a list of frame start edges.
  task automatic run_sc(input string name, input int ncyc);
    logic [7:0] fifo[$];
    int         fstart;
    logic [7:0] fbyte;
    int         next_pop;
    int         cnt_before;
    int         o;
    logic       active, exp_line;
    fstart   = -1000;
    fbyte    = 8'h00;
    next_pop = 0;
    for (int e = 0; e < ncyc; e++) begin
      tx_req  = sc_req[e];
      tx_data = sc_dat[e];
      @(posedge clk);
      #1;
      tx_req = 1'b0;
      cnt_before = fifo.size();
      if (cnt_before > 0 && e >= next_pop) begin
        fstart   = e;
        fbyte    = fifo.pop_front();
        next_pop = e + 40;
      end
      if (sc_req[e] && cnt_before < 4) begin
        fifo.push_back(sc_dat[e]);
        if (next_pop < e + 1) next_pop = e + 1;
      end
      o        = e - fstart;
      active   = (o >= 0) && (o < 40);
      exp_line = active ? frame_bit(fbyte, o) : 1'b1;
      chk({name, "_line"}, e, uart_tx, exp_line);
      chk({name, "_busy"}, e, tx_busy, fifo.size() == 4);
      chk({name, "_idle"}, e, tx_idle, (fifo.size() == 0) && !active);
    end
  endtask

  initial begin
    // 1. reset state and quiet line
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", 0, uart_tx, 1'b1);
    chk("rst_busy", 0, tx_busy, 1'b0);
    chk("rst_idle", 0, tx_idle, 1'b1);
    rst_n = 1'b1;
    clear_sc();
    run_sc("quiet", 100);

    // 2. single frame 0xA5
    clear_sc();
    sc_req[0] = 1'b1; sc_dat[0] = 8'hA5;
    run_sc("a5", 50);

    // 3. back-to-back 0x55, 0x0F
    clear_sc();
    sc_req[0] = 1'b1; sc_dat[0] = 8'h55;
    sc_req[1] = 1'b1; sc_dat[1] = 8'h0F;
    run_sc("b2b", 90);

    // 4. overfill during DATA of frame 0x00
    clear_sc();
    sc_req[0] = 1'b1; sc_dat[0] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      sc_req[10 + i] = 1'b1;
      sc_dat[10 + i] = 8'(i + 1);
    end
    run_sc("ovf", 210);

    // 5. request while full on the STOP-end pop edge
    clear_sc();
    sc_req[0] = 1'b1; sc_dat[0] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      sc_req[2 + i] = 1'b1;
      sc_dat[2 + i] = 8'(8'h22 + 8'(i * 8'h11));
    end
    sc_req[41] = 1'b1; sc_dat[41] = 8'h99;
    run_sc("fulledge", 215);

    // random traffic with a burst that fills the FIFO
    clear_sc();
    for (int e = 0; e < 500; e++) begin
      sc_req[e] = ($urandom_range(0, 19) == 0);
      sc_dat[e] = 8'($urandom);
    end
    for (int e = 200; e < 208; e++) sc_req[e] = 1'b1;
    run_sc("rand", 760);

    // 6. asynchronous reset during data bit 3 of frame 0x00
    clear_sc();
    sc_req[0] = 1'b1; sc_dat[0] = 8'h00;
    sc_req[1] = 1'b1; sc_dat[1] = 8'h3C;
    sc_req[2] = 1'b1; sc_dat[2] = 8'hFF;
    run_sc("prerst", 18);
    @(posedge clk);
    #1;
    chk("midrst_before", 18, uart_tx, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_line", 18, uart_tx, 1'b1);
    chk("midrst_idle", 18, tx_idle, 1'b1);
    chk("midrst_busy", 18, tx_busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sc();
    run_sc("postrst", 150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
